// File: rtl/vproc_mem_responder.sv
// Memory and interrupt-register responder for a VProc node.
// Each command is taken in IDLE, acked once after a programmable wait, then the bus is ignored for one GAP cycle.
module vproc_mem_responder #(
    parameter int          MEM_AW    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          RD_WAIT   = 1,
    parameter int          WR_WAIT   = 0,
    parameter int          INT_WIDTH = 3,
    parameter logic [31:0] IRQ_ADDR  = 32'hFFFF_FFF0,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                 Clk,
    input  logic                 nReset,
    input  logic [31:0]          Addr,
    input  logic [3:0]           BE,
    input  logic                 WE,
    input  logic                 RD,
    input  logic [31:0]          DataOut,
    output logic [31:0]          DataIn,
    output logic                 WRAck,
    output logic                 RDAck,
    output logic [INT_WIDTH-1:0] Interrupt,
    input  logic                 Update,
    output logic                 UpdateResponse
);

    localparam logic [3:0] RD_W = 4'(RD_WAIT);
    localparam logic [3:0] WR_W = 4'(WR_WAIT);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, GAP} state_t;

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_cnt;
    logic [31:0]         r_addr, r_wdata;
    logic [3:0]          r_be;
    logic                r_we;
    logic [31:0]         r_mem [2**MEM_AW];

    logic                w_cmd, w_ack_now;
    logic [3:0]          w_wait_sel;
    logic [31:0]         w_op_addr, w_op_data, w_rdata;
    logic [3:0]          w_op_be;
    logic                w_op_we, w_is_irq, w_in_win;
    logic [MEM_AW-1:0]   w_idx;

    // Must stay combinational so VProc sees the response in the same delta.
    assign UpdateResponse = Update;

    assign w_cmd      = WE | RD;
    assign w_wait_sel = WE ? WR_W : RD_W;

    always_comb begin
        w_state_nxt = r_state;
        w_ack_now   = 1'b0;
        w_op_addr   = r_addr;
        w_op_data   = r_wdata;
        w_op_be     = r_be;
        w_op_we     = r_we;
        case (r_state)
            IDLE: begin
                // A zero-wait command is acked on its own capture edge, so use the live bus.
                w_op_addr = Addr;
                w_op_data = DataOut;
                w_op_be   = BE;
                w_op_we   = WE;
                if (w_cmd) begin
                    w_ack_now   = (w_wait_sel == 4'd0);
                    w_state_nxt = w_ack_now ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_ack_now   = 1'b1;
                    w_state_nxt = ACK;
                end
            end
            ACK:     w_state_nxt = GAP;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_idx    = w_op_addr[MEM_AW-1:0];
    assign w_is_irq = (w_op_addr == IRQ_ADDR);
    assign w_in_win = (w_op_addr[31:MEM_AW] == BASE_ADDR[31:MEM_AW]);

    always_comb begin
        w_rdata = ERR_DATA;
        if (w_is_irq)      w_rdata = 32'(Interrupt);
        else if (w_in_win) w_rdata = r_mem[w_idx];
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_cnt     <= 4'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_be      <= 4'd0;
            r_we      <= 1'b0;
            DataIn    <= 32'd0;
            RDAck     <= 1'b0;
            WRAck     <= 1'b0;
            Interrupt <= '0;
        end else begin
            if (r_state == IDLE && w_cmd) begin
                r_addr  <= Addr;
                r_wdata <= DataOut;
                r_be    <= BE;
                r_we    <= WE;
                r_cnt   <= (w_wait_sel == 4'd0) ? 4'd0 : w_wait_sel - 4'd1;
            end else if (r_state == WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            RDAck <= w_ack_now & ~w_op_we;
            WRAck <= w_ack_now & w_op_we;
            if (w_ack_now && !w_op_we) DataIn <= w_rdata;
            if (w_ack_now && w_op_we && w_is_irq) Interrupt <= w_op_data[INT_WIDTH-1:0];
        end
    end

    // RAM is deliberately not reset; nReset only blocks a write that has not reached its ack edge.
    always_ff @(posedge Clk) begin
        if (nReset && w_ack_now && w_op_we && !w_is_irq && w_in_win) begin
            for (int n = 0; n < 4; n++) begin
                if (w_op_be[n]) r_mem[w_idx][8*n +: 8] <= w_op_data[8*n +: 8];
            end
        end
    end

endmodule

// File: tb/tb_vproc_mem_responder.sv
// Scoreboard bench for vproc_mem_responder: the driver queues expected acks (kind, edge, data),
// and a negedge monitor checks each ack the DUT raises against the queue.
module tb_vproc_mem_responder;

    localparam int RDW = 1;
    localparam int WRW = 2;
    localparam logic [31:0] IRQ = 32'hFFFF_FFF0;

    logic        Clk = 0, nReset = 0;
    logic [31:0] Addr = 0, DataOut = 0, DataIn;
    logic [3:0]  BE = 0;
    logic        WE = 0, RD = 0, WRAck, RDAck, Update = 0, UpdateResponse;
    logic [2:0]  Interrupt;

    typedef struct {bit rd; logic [31:0] data; int cyc;} exp_t;
    exp_t q[$];
    int checks = 0, failures = 0, cyc = 0;

    vproc_mem_responder #(.MEM_AW(12), .BASE_ADDR(32'h0), .RD_WAIT(RDW), .WR_WAIT(WRW),
                          .INT_WIDTH(3), .IRQ_ADDR(IRQ), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .Clk(Clk), .nReset(nReset), .Addr(Addr), .BE(BE), .WE(WE), .RD(RD),
        .DataOut(DataOut), .DataIn(DataIn), .WRAck(WRAck), .RDAck(RDAck),
        .Interrupt(Interrupt), .Update(Update), .UpdateResponse(UpdateResponse));

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (nReset && (RDAck || WRAck)) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ack cyc=%0d rd=%b wr=%b", cyc, RDAck, WRAck);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (RDAck != e.rd || WRAck == e.rd || cyc != e.cyc || (e.rd && DataIn !== e.data)) begin
                    failures++;
                    $display("FAIL ack_match got rd=%b wr=%b cyc=%0d data=%h exp rd=%b cyc=%0d data=%h",
                             RDAck, WRAck, cyc, DataIn, e.rd, e.cyc, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT back in IDLE.
    task automatic op(input bit we, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] d, input logic [31:0] exp_rd, input bit hold);
        exp_t e;
        bit   got;
        WE = we; RD = !we; Addr = a; BE = be; DataOut = d;
        e.rd = !we; e.data = exp_rd; e.cyc = cyc + 1 + (we ? WRW : RDW);
        q.push_back(e);
        got = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            if (RDAck || WRAck) begin got = 1; break; end
        end
        checks++;
        if (!got) begin failures++; $display("FAIL ack_timeout addr=%h got=none exp=ack", a); end
        if (!hold) begin WE = 0; RD = 0; end
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        chk("reset_datain", DataIn, 32'h0);
        chk("reset_acks", {30'h0, RDAck, WRAck}, 32'h0);
        chk("reset_irq", 32'(Interrupt), 32'h0);
        nReset = 1;
        @(negedge Clk);

        op(1, 32'h10, 4'hF, 32'h1234_5678, 0, 0);
        op(0, 32'h10, 4'hF, 0, 32'h1234_5678, 0);

        op(1, 32'h20, 4'hF, 32'hAABB_CCDD, 0, 0);
        op(1, 32'h20, 4'b0101, 32'h1122_3344, 0, 0);
        op(0, 32'h20, 4'hF, 0, 32'hAA22_CC44, 0);
        op(1, 32'h21, 4'h0, 32'hFFFF_FFFF, 0, 0);
        op(0, 32'h21, 4'hF, 0, 32'hxxxx_xxxx, 0);   // BE=0 write: only the ack is checked, data is don't-care

        for (int i = 0; i < 4; i++) op(1, 32'h30 + i, 4'hF, 32'hC0DE_0000 + i, 0, 0);
        for (int i = 0; i < 4; i++) op(0, 32'h30 + i, 4'hF, 0, 32'hC0DE_0000 + i, i != 3);

        op(0, 32'h8000_0000, 4'hF, 0, 32'hDEAD_BEEF, 0);
        op(1, 32'h8000_0010, 4'hF, 32'h5555_5555, 0, 0);
        op(0, 32'h10, 4'hF, 0, 32'h1234_5678, 0);

        op(1, IRQ, 4'h0, 32'h0000_0005, 0, 0);
        chk("irq_set", 32'(Interrupt), 32'h5);
        op(0, IRQ, 4'hF, 0, 32'h0000_0005, 0);
        op(1, IRQ, 4'hF, 32'h0, 0, 0);
        chk("irq_clear", 32'(Interrupt), 32'h0);
        op(1, IRQ, 4'hF, 32'h3, 0, 0);

        op(1, 32'h40, 4'hF, 32'h1111_1111, 0, 0);
        WE = 1; Addr = 32'h40; BE = 4'hF; DataOut = 32'h2222_2222;
        @(negedge Clk);
        nReset = 0; WE = 0;
        repeat (3) @(negedge Clk);
        chk("abort_outputs", {DataIn[28:0], RDAck, WRAck, |Interrupt}, 32'h0);
        nReset = 1;
        @(negedge Clk);
        op(0, 32'h40, 4'hF, 0, 32'h1111_1111, 0);

        Update = 1; #1;
        chk("update_rise", {31'h0, UpdateResponse}, 32'h1);
        Update = 0; #1;
        chk("update_fall", {31'h0, UpdateResponse}, 32'h0);

        repeat (5) @(negedge Clk);
        chk("queue_empty", q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
